// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its bit slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Mode encoding for the register's MODE port. All four codes are legal.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_cell.sv
// One bit slice of the universal register: 4:1 source mux into a negedge flop.
// Latency: selected source visible on q right after the sampling falling edge.
// Backpressure: none; en=0 simply holds the stored bit.
//
// Ports:
//   clk, rst    falling-edge clock, synchronous active-high reset
//   en, mode    operation enable and mode select (usr_pkg encoding)
//   shr_src     bit taken on a right shift (upper neighbour or serial/rotate end)
//   shl_src     bit taken on a left shift (lower neighbour or serial/rotate end)
//   d           parallel load bit
//   q, nq       stored bit and its complement
module usr_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       shr_src,
  input  logic       shl_src,
  input  logic       d,
  output logic       q,
  output logic       nq
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_HOLD: q_nxt = q;
      MODE_SHR:  q_nxt = shr_src;
      MODE_SHL:  q_nxt = shl_src;
      MODE_LOAD: q_nxt = d;
      default:   q_nxt = q;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q_nxt;
    end
  end

  assign nq = ~q;

endmodule

// File: rtl/usr_negedge_reg.sv
// WIDTH-bit universal register (hold / shift right / shift left / load), falling-edge clocked.
// Latency: one cycle; loads and shifts appear on Q right after the sampling falling edge.
// Backpressure: none; EN=0 holds the contents and the shift count.
//
// Ports:
//   CLK, RST        falling-edge clock, synchronous active-high reset
//   EN, MODE        enable and operation select (usr_pkg encoding)
//   D               parallel load data
//   SIN_R, SIN_L    serial inputs entering at the MSB (right shift) / LSB (left shift)
//   Q, NQ           contents and their complement
//   SOUT_R, SOUT_L  bits that leave on the next right / left shift
//   CNT, DONE       shifts since last load or reset (saturating at WIDTH), CNT==WIDTH
module usr_negedge_reg
  import usr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROTATE = 0,
  parameter int CW     = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_R,
  input  logic             SIN_L,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             SOUT_R,
  output logic             SOUT_L,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] nq_w;
  logic             ins_r;
  logic             ins_l;
  logic [CW-1:0]    cnt_q;

  // End-cell feeds: in rotate mode the bit falling off one end re-enters at the other.
  assign ins_r = (ROTATE != 0) ? q_w[0]       : SIN_R;
  assign ins_l = (ROTATE != 0) ? q_w[WIDTH-1] : SIN_L;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shr_src;
    logic shl_src;

    if (i == WIDTH - 1) begin : g_top
      assign shr_src = ins_r;
    end else begin : g_mid_r
      assign shr_src = q_w[i+1];
    end

    if (i == 0) begin : g_bot
      assign shl_src = ins_l;
    end else begin : g_mid_l
      assign shl_src = q_w[i-1];
    end

    usr_cell u_cell (
      .clk     (CLK),
      .rst     (RST),
      .en      (EN),
      .mode    (MODE),
      .shr_src (shr_src),
      .shl_src (shl_src),
      .d       (D[i]),
      .q       (q_w[i]),
      .nq      (nq_w[i])
    );
  end

  // Shift counter: cleared by load, saturates at WIDTH so DONE stays up after a drain.
  always_ff @(negedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (EN) begin
      case (MODE)
        MODE_LOAD: cnt_q <= '0;
        MODE_SHR,
        MODE_SHL: begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign Q      = q_w;
  assign NQ     = nq_w;
  assign SOUT_R = q_w[0];
  assign SOUT_L = q_w[WIDTH-1];
  assign CNT    = cnt_q;
  assign DONE   = (cnt_q == CNT_MAX);

endmodule

// File: doc/usr_negedge_reg.md
Name: usr_negedge_reg

Overview:
Parametrised, negative-edge-triggered register that generalises the single-bit D flip-flop to WIDTH bits.
- Adds four operating modes: hold, shift right, shift left and parallel load.
- Adds serial in/out on both ends, optional rotate, and a shift counter with a done flag.
- Used as the standard SIPO/PISO and storage register in the gate-level datapath; keeps the Q/NQ complementary-output style.

Parameters:
WIDTH, 8, register width in bits; legal values are WIDTH >= 2.
ROTATE, 0, 0 means shifts insert SIN_R/SIN_L; 1 means shifts recirculate the bit shifted out (circular).
CW, $clog2(WIDTH+1), width of CNT; derived, not overridden.

Ports:
CLK  input  1  clock; all state changes on the falling edge.
RST  input  1  synchronous, active-high reset; sampled on the falling edge of CLK.
EN  input  1  operation enable; 0 forces hold.
MODE  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
D  input  WIDTH  parallel load data.
SIN_R  input  1  serial input inserted at the MSB on shift right.
SIN_L  input  1  serial input inserted at the LSB on shift left.
Q  output  WIDTH  register contents.
NQ  output  WIDTH  bitwise complement of Q, at all times.
SOUT_R  output  1  equals Q[0], the bit leaving on the next right shift.
SOUT_L  output  1  equals Q[WIDTH-1], the bit leaving on the next left shift.
CNT  output  CW  shifts since the last load or reset; saturates at WIDTH.
DONE  output  1  1 when CNT == WIDTH.

Behaviour:
- All registers update only on the falling edge of CLK. A rising edge never changes any output.
- Reset (RST=1 at a falling edge):
  - Q=0, NQ=all ones, CNT=0, DONE=0, SOUT_R=0, SOUT_L=0.
  - Reset has priority over EN and MODE.
  - Reset mid-sequence discards the register contents and the count.
- Priority at each falling edge: RST, then EN=0 (hold everything), then MODE.
- MODE=00 (hold): Q and CNT unchanged.
- MODE=01 (shift right):
  - Q <= {ins, Q[WIDTH-1:1]}, where ins = SIN_R if ROTATE=0, else Q[0].
- MODE=10 (shift left):
  - Q <= {Q[WIDTH-2:0], ins}, where ins = SIN_L if ROTATE=0, else Q[WIDTH-1].
- MODE=11 (load): Q <= D; CNT <= 0.
- Counter:
  - Each shift with EN=1 increments CNT by 1, saturating at WIDTH; no wrap-around.
  - Hold leaves CNT unchanged.
- DONE is decoded combinationally from registered CNT, so it is valid in the same half-cycle as CNT.
- NQ, SOUT_R and SOUT_L are combinational from Q; there is no extra latency.
- Latency: a load or shift is visible on Q immediately after the sampling falling edge, i.e. one cycle.
- There are no illegal MODE encodings.
- Inputs must be stable around the falling edge; there is no metastability handling inside the block.

Decomposition:
- Shared package usr_pkg holds the mode constants:
  - MODE_HOLD=2'b00
  - MODE_SHR=2'b01
  - MODE_SHL=2'b10
  - MODE_LOAD=2'b11
- One natural sub-module, usr_cell: a single bit slice.
  - It contains a 4:1 mux (hold / right neighbour / left neighbour / D bit) feeding a negedge flop with synchronous reset, and outputs q and nq.
  - Top level instantiates WIDTH cells with a generate loop.
  - End-cell neighbour inputs are driven by the serial-in/rotate select.
  - Counter and DONE live in the top level.

Test Plan:
Run with WIDTH=4 unless noted.
1. Reset: RST=1 across one falling edge, MODE=11, D=1111 -> Q=0000, NQ=1111, CNT=0, DONE=0. A rising edge with RST=1 alone changes nothing.
2. Load: EN=1, MODE=11, D=1011 -> after the falling edge Q=1011, NQ=0100, CNT=0, SOUT_R=1, SOUT_L=1. Q does not change on the preceding rising edge.
3. Shift-right drain: from Q=1011, five right shifts with SIN_R=0, ROTATE=0 ->
   - Q goes 0101, 0010, 0001, 0000, 0000.
   - SOUT_R before each of the first four shifts is 1, 1, 0, 1.
   - CNT goes 1, 2, 3, 4, 4.
   - DONE=1 from the fourth shift onward.
4. Rotate left: ROTATE=1, load 1001, two left shifts (SIN_L=0, ignored) -> Q=0011 then 0110, CNT=2, DONE=0.
5. Enable and priority:
   - EN=0, MODE=01 for 3 edges -> Q and CNT unchanged.
   - Then RST=1 with EN=0 -> Q=0000, CNT=0.
6. Reset mid-operation: load 1100, shift left twice with SIN_L=1 -> Q=0011, CNT=2. Then assert RST with MODE=10 -> Q=0000, CNT=0. Then one shift left with SIN_L=1 -> Q=0001, CNT=1.
